// File: rtl/fclassify_arb.sv
// -----------------------------------------------------------------------------
// fclassify_arb
//
// Shares one floating-point classify datapath among NREQ requesters. A
// round-robin arbiter grants at most one requester per cycle; the granted
// operand is decoded (single with NaN-boxing check, or double) and its
// 10-bit RISC-V class mask is captured in a one-entry output register that
// supports backpressure. A drain and a new grant may happen in the same
// cycle, so sustained throughput is one result per cycle.
//
// Ports
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   Flush      in   drop the held result, no grant this cycle
//   ReqValid   in   [NREQ]       request valid per requester
//   ReqReady   out  [NREQ]       one-hot grant (or zero)
//   ReqX       in   [NREQ*FLEN]  operand, requester i at [i*FLEN +: FLEN]
//   ReqFmt     in   [NREQ]       0 = single, 1 = double (ignored if FLEN=32)
//   ReqTag     in   [NREQ*TAGW]  opaque tag returned with the result
//   ResValid   out  result valid
//   ResReady   in   consumer accepts the result
//   ResClass   out  [XLEN]       class mask, bits XLEN-1:10 are zero
//   ResId      out  [log2 NREQ]  requester that produced the result
//   ResTag     out  [TAGW]       tag of that request
// -----------------------------------------------------------------------------
module fclassify_arb #(
  parameter int NREQ = 4,
  parameter int XLEN = 64,
  parameter int FLEN = 64,
  parameter int TAGW = 5,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   Flush,
  input  logic [NREQ-1:0]        ReqValid,
  output logic [NREQ-1:0]        ReqReady,
  input  logic [NREQ*FLEN-1:0]   ReqX,
  input  logic [NREQ-1:0]        ReqFmt,
  input  logic [NREQ*TAGW-1:0]   ReqTag,
  output logic                   ResValid,
  input  logic                   ResReady,
  output logic [XLEN-1:0]        ResClass,
  output logic [IDW-1:0]         ResId,
  output logic [TAGW-1:0]        ResTag
);

  // ---------------------------------------------------------------------------
  // Operand decode and classification
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] classify(input logic [FLEN-1:0] x, input logic fmt);
    logic [63:0] w;
    logic        sign;
    logic        exp_zero;
    logic        exp_ones;
    logic        frac_zero;
    logic        frac_msb;
    logic        is_zero;
    logic        is_sub;
    logic        is_inf;
    logic        is_nan;
    logic        is_snan;
    logic        is_norm;
    logic [9:0]  cls;
    w = 64'(x);
    if (FLEN == 64 && fmt) begin
      sign      = w[63];
      exp_zero  = ~|w[62:52];
      exp_ones  = &w[62:52];
      frac_zero = ~|w[51:0];
      frac_msb  = w[51];
    end else begin
      // An improperly NaN-boxed single reads as the canonical quiet NaN.
      if (FLEN == 64 && !(&w[63:32])) w[31:0] = 32'h7FC0_0000;
      sign      = w[31];
      exp_zero  = ~|w[30:23];
      exp_ones  = &w[30:23];
      frac_zero = ~|w[22:0];
      frac_msb  = w[22];
    end
    is_zero = exp_zero & frac_zero;
    is_sub  = exp_zero & ~frac_zero;
    is_inf  = exp_ones & frac_zero;
    is_nan  = exp_ones & ~frac_zero;
    is_snan = is_nan & ~frac_msb;
    is_norm = ~exp_zero & ~exp_ones;
    cls    = '0;
    cls[0] = is_inf  &  sign;
    cls[1] = is_norm &  sign;
    cls[2] = is_sub  &  sign;
    cls[3] = is_zero &  sign;
    cls[4] = is_zero & ~sign;
    cls[5] = is_sub  & ~sign;
    cls[6] = is_norm & ~sign;
    cls[7] = is_inf  & ~sign;
    cls[8] = is_snan;             // sign is irrelevant for NaNs
    cls[9] = is_nan & ~is_snan;
    return cls;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]  r_last;
  logic            r_res_valid;
  logic [9:0]      r_res_class;
  logic [IDW-1:0]  r_res_id;
  logic [TAGW-1:0] r_res_tag;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic            w_gnt_en;
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt_idx;
  logic [IDW:0]    w_scan;      // one spare bit so last+k cannot overflow
  logic [FLEN-1:0] w_gnt_x;
  logic [TAGW-1:0] w_gnt_tag;
  logic            w_gnt_fmt;
  logic [9:0]      w_gnt_class;

  // Output slot is free when empty or being drained this cycle.
  assign w_gnt_en = (~r_res_valid | ResReady) & ~Flush;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_scan = {1'b0, r_last} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(NREQ)) w_scan = w_scan - (IDW+1)'(NREQ);
      if (w_gnt_en && !w_gnt_vld && ReqValid[w_scan[IDW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    ReqReady = '0;
    if (w_gnt_vld) ReqReady[w_gnt_idx] = 1'b1;
  end

  assign w_gnt_x     = ReqX[w_gnt_idx*FLEN +: FLEN];
  assign w_gnt_tag   = ReqTag[w_gnt_idx*TAGW +: TAGW];
  assign w_gnt_fmt   = ReqFmt[w_gnt_idx];
  assign w_gnt_class = classify(w_gnt_x, w_gnt_fmt);

  // ---------------------------------------------------------------------------
  // Output stage and pointer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last      <= IDW'(NREQ - 1);
      r_res_valid <= 1'b0;
      r_res_class <= '0;
      r_res_id    <= '0;
      r_res_tag   <= '0;
    end else if (Flush) begin
      r_res_valid <= 1'b0;
    end else if (w_gnt_vld) begin
      // Replaces the draining result in the same cycle: no bubble.
      r_res_valid <= 1'b1;
      r_res_class <= w_gnt_class;
      r_res_id    <= w_gnt_idx;
      r_res_tag   <= w_gnt_tag;
      r_last      <= w_gnt_idx;
    end else if (ResReady) begin
      r_res_valid <= 1'b0;
    end
  end

  assign ResValid = r_res_valid;
  assign ResClass = {{(XLEN-10){1'b0}}, r_res_class};
  assign ResId    = r_res_id;
  assign ResTag   = r_res_tag;

endmodule

// File: tb/tb_fclassify_arb.sv
// -----------------------------------------------------------------------------
// tb_fclassify_arb
//
// Self-checking bench for fclassify_arb. A behavioural model tracks the
// expected pointer and output slot; classification is modelled by comparing
// operand magnitudes against format boundaries rather than by field decode.
// Inputs are driven 1 time unit after the rising edge; the combinational
// grant is checked 1 unit later and registered outputs 1 unit after the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_fclassify_arb;

  localparam int NREQ = 4;
  localparam int XLEN = 64;
  localparam int FLEN = 64;
  localparam int TAGW = 5;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 Flush;
  logic [NREQ-1:0]      ReqValid;
  logic [NREQ-1:0]      ReqReady;
  logic [NREQ*FLEN-1:0] ReqX;
  logic [NREQ-1:0]      ReqFmt;
  logic [NREQ*TAGW-1:0] ReqTag;
  logic                 ResValid;
  logic                 ResReady;
  logic [XLEN-1:0]      ResClass;
  logic [IDW-1:0]       ResId;
  logic [TAGW-1:0]      ResTag;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic            m_valid;
  logic [9:0]      m_class;
  int              m_id;
  logic [TAGW-1:0] m_tag;
  int              m_last;

  fclassify_arb #(.NREQ(NREQ), .XLEN(XLEN), .FLEN(FLEN), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqX(ReqX),
    .ReqFmt(ReqFmt), .ReqTag(ReqTag),
    .ResValid(ResValid), .ResReady(ResReady), .ResClass(ResClass),
    .ResId(ResId), .ResTag(ResTag)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] ref_class(input logic [63:0] x, input logic fmt);
    logic [63:0] mag, min_norm, inf, qnan_min;
    logic [31:0] s;
    logic        neg;
    int          b;
    if (fmt) begin
      neg      = x[63];
      mag      = {1'b0, x[62:0]};
      min_norm = 64'h0010_0000_0000_0000;
      inf      = 64'h7FF0_0000_0000_0000;
      qnan_min = 64'h7FF8_0000_0000_0000;
    end else begin
      s        = (x[63:32] == 32'hFFFF_FFFF) ? x[31:0] : 32'h7FC0_0000;
      neg      = s[31];
      mag      = {33'b0, s[30:0]};
      min_norm = 64'h0080_0000;
      inf      = 64'h7F80_0000;
      qnan_min = 64'h7FC0_0000;
    end
    if (mag == 0)             b = neg ? 3 : 4;
    else if (mag < min_norm)  b = neg ? 2 : 5;
    else if (mag < inf)       b = neg ? 1 : 6;
    else if (mag == inf)      b = neg ? 0 : 7;
    else if (mag < qnan_min)  b = 8;
    else                      b = 9;
    return 10'b1 << b;
  endfunction

  function automatic int model_grant();
    if (Flush || (m_valid && !ResReady)) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (ReqValid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    if (g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_class = '0; m_id = 0; m_tag = '0; m_last = NREQ - 1;
  endtask

  // Advance the model by one clock using the current (pre-edge) inputs.
  task automatic model_clock();
    int g;
    g = model_grant();
    if (Flush) m_valid = 1'b0;
    else if (g >= 0) begin
      m_valid = 1'b1;
      m_class = ref_class(ReqX[g*FLEN +: FLEN], ReqFmt[g]);
      m_id    = g;
      m_tag   = ReqTag[g*TAGW +: TAGW];
      m_last  = g;
    end else if (ResReady) m_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ---------------------------------------------------------------------------
  task automatic set_req(input int i, input logic [63:0] x, input logic fmt,
                         input logic [TAGW-1:0] tag);
    ReqValid[i]             = 1'b1;
    ReqX[i*FLEN +: FLEN]    = x;
    ReqFmt[i]               = fmt;
    ReqTag[i*TAGW +: TAGW]  = tag;
  endtask

  task automatic clear_reqs();
    ReqValid = '0;
  endtask

  function automatic logic [63:0] rand_operand(input logic fmt);
    logic [63:0] v;
    logic [10:0] e11;
    logic [51:0] f52;
    logic [7:0]  e8;
    logic [22:0] f23;
    int          sel;
    v = {$urandom, $urandom};
    if (fmt) begin
      sel = $urandom_range(0, 3);
      e11 = (sel == 0) ? 11'h000 : (sel == 1) ? 11'h7FF : v[62:52];
      sel = $urandom_range(0, 3);
      f52 = (sel == 0) ? 52'h0 : (sel == 1) ? {1'b1, 51'h0} : v[51:0];
      return {v[63], e11, f52};
    end
    sel = $urandom_range(0, 3);
    e8  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : v[30:23];
    sel = $urandom_range(0, 3);
    f23 = (sel == 0) ? 23'h0 : (sel == 1) ? {1'b1, 22'h0} : v[22:0];
    if ($urandom_range(0, 3) != 0) return {32'hFFFF_FFFF, v[31], e8, f23};
    return {v[63:32], v[31], e8, f23};
  endfunction

  task automatic randomize_all_reqs();
    for (int i = 0; i < NREQ; i++) begin
      logic f;
      f = 1'($urandom);
      set_req(i, rand_operand(f), f, TAGW'($urandom));
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; Flush = 1'b0; ResReady = 1'b0; ReqValid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0; Flush = 1'b0; ResReady = 1'b0; ReqValid = '0;
    ReqX = '0; ReqFmt = '0; ReqTag = '0;
    model_reset();
    #3;
    n_checks++;
    if (ResValid !== 1'b0 || ResClass !== '0 || ResId !== '0 || ResTag !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b class=%h id=%0d tag=%0d, want all zero",
               ResValid, ResClass, ResId, ResTag);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic_and_formats();
    logic [63:0] xs   [6] = '{64'h8000_0000_0000_0000, 64'hFFF0_0000_0000_0000,
                              64'h0000_0000_0000_0001, 64'hFFFF_FFFF_7F80_0001,
                              64'hFFFF_FFFF_FFC0_0000, 64'h0000_0000_3F80_0000};
    logic        fmts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [9:0]  want [6] = '{10'h008, 10'h001, 10'h020, 10'h100, 10'h200, 10'h200};
    // First transaction: requester 0, single +1.0, tag 3.
    clear_reqs(); ResReady = 1'b1; Flush = 1'b0;
    set_req(0, 64'hFFFF_FFFF_3F80_0000, 1'b0, 5'd3);
    #1;
    n_checks++;
    if (ReqReady !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_grant: got %b, want 0001", ReqReady);
    end
    model_clock();
    @(posedge clk); #1;
    n_checks++;
    if (ResValid !== 1'b1 || ResClass !== 64'h040 || ResId !== 2'd0 || ResTag !== 5'd3) begin
      n_fail++;
      $display("FAIL basic_result: got valid=%b class=%h id=%0d tag=%0d, want 1 040 0 3",
               ResValid, ResClass, ResId, ResTag);
    end
    for (int e = 0; e < 6; e++) begin
      clear_reqs();
      set_req(e % NREQ, xs[e], fmts[e], TAGW'(e + 10));
      #1;
      n_checks++;
      if (ReqReady !== onehot(e % NREQ)) begin
        n_fail++;
        $display("FAIL fmt_grant[%0d]: got %b, want %b", e, ReqReady, onehot(e % NREQ));
      end
      model_clock();
      @(posedge clk); #1;
      n_checks++;
      if (ResValid !== 1'b1 || ResClass !== 64'(want[e]) || ResTag !== TAGW'(e + 10)) begin
        n_fail++;
        $display("FAIL fmt_class[%0d]: got valid=%b class=%h tag=%0d, want 1 %h %0d",
                 e, ResValid, ResClass, ResTag, want[e], e + 10);
      end
    end
    clear_reqs();
    model_clock();
    @(posedge clk); #1;
    n_checks++;
    if (ResValid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: got valid=%b, want 0", ResValid);
    end
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    ResReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      randomize_all_reqs();
      #1;
      n_checks++;
      if (ReqReady !== onehot(seq[c])) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b, want %b", c, ReqReady, onehot(seq[c]));
      end
      model_clock();
      @(posedge clk); #1;
      n_checks++;
      if (ResValid !== 1'b1 || ResId !== IDW'(seq[c]) || ResClass !== 64'(m_class)
          || ResTag !== m_tag) begin
        n_fail++;
        $display("FAIL rr_result[%0d]: got valid=%b id=%0d class=%h tag=%0d, want 1 %0d %h %0d",
                 c, ResValid, ResId, ResClass, ResTag, seq[c], m_class, m_tag);
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt;
    ResReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      randomize_all_reqs();
      #1;
      n_checks++;
      if (ReqReady !== '0) begin
        n_fail++;
        $display("FAIL bp_no_grant[%0d]: got %b, want 0000", c, ReqReady);
      end
      model_clock();
      @(posedge clk); #1;
      n_checks++;
      if (ResValid !== 1'b1 || ResClass !== 64'(m_class) || ResId !== IDW'(m_id)
          || ResTag !== m_tag) begin
        n_fail++;
        $display("FAIL bp_stable[%0d]: got valid=%b class=%h id=%0d tag=%0d, want 1 %h %0d %0d",
                 c, ResValid, ResClass, ResId, ResTag, m_class, m_id, m_tag);
      end
    end
    ResReady = 1'b1;
    randomize_all_reqs();
    nxt = (m_id + 1) % NREQ;
    #1;
    n_checks++;
    if (ReqReady !== onehot(nxt)) begin
      n_fail++;
      $display("FAIL bp_release_grant: got %b, want %b", ReqReady, onehot(nxt));
    end
    model_clock();
    @(posedge clk); #1;
    n_checks++;
    if (ResValid !== 1'b1 || ResId !== IDW'(nxt) || ResClass !== 64'(m_class)) begin
      n_fail++;
      $display("FAIL bp_release_result: got valid=%b id=%0d class=%h, want 1 %0d %h",
               ResValid, ResId, ResClass, nxt, m_class);
    end
  endtask

  task automatic test_flush();
    int saved_last;
    saved_last = m_last;
    ResReady = 1'b1; Flush = 1'b1;
    randomize_all_reqs();
    #1;
    n_checks++;
    if (ReqReady !== '0) begin
      n_fail++;
      $display("FAIL flush_no_grant: got %b, want 0000", ReqReady);
    end
    model_clock();
    @(posedge clk); #1;
    n_checks++;
    if (ResValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: got valid=%b, want 0", ResValid);
    end
    Flush = 1'b0;
    randomize_all_reqs();
    #1;
    n_checks++;
    if (ReqReady !== onehot((saved_last + 1) % NREQ)) begin
      n_fail++;
      $display("FAIL flush_next_grant: got %b, want %b", ReqReady,
               onehot((saved_last + 1) % NREQ));
    end
    model_clock();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      randomize_all_reqs();
      ReqValid = NREQ'($urandom);
      ResReady = ($urandom_range(0, 9) < 7);
      Flush    = ($urandom_range(0, 19) == 0);
      #1;
      n_checks++;
      if (ReqReady !== onehot(model_grant())) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: got %b, want %b", c, ReqReady, onehot(model_grant()));
      end
      model_clock();
      @(posedge clk); #1;
      n_checks++;
      if (ResValid !== m_valid) begin
        n_fail++;
        $display("FAIL rand_valid[%0d]: got %b, want %b", c, ResValid, m_valid);
      end else if (m_valid) begin
        n_checks++;
        if (ResClass !== 64'(m_class) || ResId !== IDW'(m_id) || ResTag !== m_tag) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got class=%h id=%0d tag=%0d, want %h %0d %0d",
                   c, ResClass, ResId, ResTag, m_class, m_id, m_tag);
        end
      end
    end
    Flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Leave a result pending, then pulse reset between clock edges.
    ResReady = 1'b1;
    randomize_all_reqs();
    model_clock();
    @(posedge clk); #1;
    ResReady = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ResValid !== 1'b0 || ResClass !== '0 || ResId !== '0 || ResTag !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b class=%h id=%0d tag=%0d, want all zero",
               ResValid, ResClass, ResId, ResTag);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    ReqValid = '1;
    ResReady = 1'b1;
    #1;
    n_checks++;
    if (ReqReady !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_first_grant: got %b, want 0001", ReqReady);
    end
    model_clock();
    @(posedge clk); #1;
    n_checks++;
    if (ResValid !== 1'b1 || ResId !== '0 || ResClass !== 64'(m_class)) begin
      n_fail++;
      $display("FAIL midreset_result: got valid=%b id=%0d class=%h, want 1 0 %h",
               ResValid, ResId, ResClass, m_class);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic_and_formats();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
